// File: rtl/flit_sink_pkg.sv
// Shared definitions for the NoC ejection path: flit field layout, flit type
// codes and reassembly state encodings, reused by injector and credit logic.
package flit_sink_pkg;

    localparam int FLIT_TYPE_W  = 2;
    localparam int FLIT_VALID_W = 1;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_IN_PKT = 2'b01,
        ST_DONE   = 2'b10
    } rx_state_e;

    // Field offsets, MSB first: valid | type | src | payload.
    function automatic int flit_src_lsb(input int data_size);
        return data_size;
    endfunction

    function automatic int flit_type_lsb(input int data_size, input int router_bit);
        return data_size + router_bit;
    endfunction

    function automatic int flit_valid_pos(input int data_size, input int router_bit);
        return data_size + router_bit + FLIT_TYPE_W;
    endfunction

endpackage

// File: rtl/flit_sink_fifo.sv
// Synchronous FIFO with registered pointers and count; a push while full is
// accepted only together with a pop. Read data is the current head entry.
module sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_s, empty_s, wr_en_s, rd_en_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});
    assign rd_en_s = pop && !empty_s;
    assign wr_en_s = push && (!full_s || rd_en_s);

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_s;
    assign empty   = empty_s;
    assign count   = count_q;

endmodule

// File: rtl/flit_sink.sv
// NoC ejection endpoint: buffers incoming flits, reassembles packets, returns
// one credit per popped flit and accumulates packet count and latency.
module flit_sink
    import flit_sink_pkg::*;
#(
    parameter int ROUTER_BIT = 4,
    parameter int DATA_SIZE  = 32,
    parameter int CYCLE_SIZE = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_SIZE   = 16,
    parameter int LAT_SIZE   = 32,
    parameter int FLIT_SIZE  = 3 + ROUTER_BIT + DATA_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_SIZE-1:0]  in_flit,
    input  logic                  drain_en,
    input  logic [CYCLE_SIZE-1:0] cur_cycle,
    input  logic [CNT_SIZE-1:0]   expected_pkts,
    output logic                  credit_out,
    output logic [CNT_SIZE-1:0]   pkt_count,
    output logic [LAT_SIZE-1:0]   lat_sum,
    output logic [ROUTER_BIT-1:0] last_src,
    output logic                  done,
    output logic                  error
);

    localparam int SRC_LSB   = flit_src_lsb(DATA_SIZE);
    localparam int TYPE_LSB  = flit_type_lsb(DATA_SIZE, ROUTER_BIT);
    localparam int VALID_POS = flit_valid_pos(DATA_SIZE, ROUTER_BIT);
    localparam int FCNT_W    = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    logic                  fifo_full_s, fifo_empty_s, fifo_push_s;
    logic [FCNT_W-1:0]     fifo_count_s;
    logic [FLIT_SIZE-1:0]  head_flit_s;
    logic                  in_valid_s, pop_s, overflow_s;
    flit_type_e            pop_type_s;
    logic [ROUTER_BIT-1:0] pop_src_s;
    logic [CYCLE_SIZE-1:0] pop_cycle_s;
    logic                  unused_s;

    rx_state_e             state_q, state_d;
    logic                  complete_s, restart_s, proto_err_s, enter_done_s;
    logic [ROUTER_BIT-1:0] cmpl_src_s;
    logic [CYCLE_SIZE-1:0] cmpl_inj_s, lat_s;
    logic [LAT_SIZE:0]     sum_s;

    logic                  credit_q, credit_d;
    logic [CNT_SIZE-1:0]   pkt_count_q, pkt_count_d;
    logic [LAT_SIZE-1:0]   lat_sum_q, lat_sum_d;
    logic [ROUTER_BIT-1:0] last_src_q, last_src_d;
    logic [ROUTER_BIT-1:0] pkt_src_q, pkt_src_d;
    logic [CYCLE_SIZE-1:0] inj_cycle_q, inj_cycle_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    assign in_valid_s  = in_flit[VALID_POS];
    assign pop_s       = drain_en && !fifo_empty_s;
    assign overflow_s  = in_valid_s && fifo_full_s && !pop_s;
    assign fifo_push_s = in_valid_s && !overflow_s;

    sink_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push_s),
        .pop     (pop_s),
        .wr_data (in_flit),
        .rd_data (head_flit_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign pop_type_s  = flit_type_e'(head_flit_s[TYPE_LSB +: FLIT_TYPE_W]);
    assign pop_src_s   = head_flit_s[SRC_LSB +: ROUTER_BIT];
    assign pop_cycle_s = head_flit_s[CYCLE_SIZE-1:0];
    assign unused_s    = ^{fifo_count_s, head_flit_s};

    // Reassembly state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reassembly next state; DONE is entered as soon as the target count is hit
    always_comb begin
        state_d = state_q;
        if (pop_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_type_s == FT_HEAD) begin
                        state_d = ST_IN_PKT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IN_PKT: begin
                    if ((pop_type_s == FT_TAIL) || (pop_type_s == FT_SINGLE)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IN_PKT;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        if ((state_q != ST_DONE) && enter_done_s) begin
            state_d = ST_DONE;
        end else begin
            state_d = state_d;
        end
    end

    // Per-flit actions of the reassembly FSM
    always_comb begin
        complete_s  = 1'b0;
        restart_s   = 1'b0;
        proto_err_s = 1'b0;
        cmpl_src_s  = pkt_src_q;
        cmpl_inj_s  = inj_cycle_q;
        if (pop_s) begin
            case (state_q)
                ST_IDLE: begin
                    case (pop_type_s)
                        FT_HEAD:   restart_s = 1'b1;
                        FT_SINGLE: begin
                            complete_s = 1'b1;
                            cmpl_src_s = pop_src_s;
                            cmpl_inj_s = pop_cycle_s;
                        end
                        default:   proto_err_s = 1'b1;
                    endcase
                end
                ST_IN_PKT: begin
                    case (pop_type_s)
                        FT_BODY:   complete_s = 1'b0;
                        FT_TAIL:   complete_s = 1'b1;
                        FT_HEAD: begin
                            proto_err_s = 1'b1;
                            restart_s   = 1'b1;
                        end
                        default: begin
                            proto_err_s = 1'b1;
                            complete_s  = 1'b1;
                            cmpl_src_s  = pop_src_s;
                            cmpl_inj_s  = pop_cycle_s;
                        end
                    endcase
                end
                ST_DONE: begin
                    if (pop_type_s != FT_BODY) begin
                        proto_err_s = 1'b1;
                    end else begin
                        proto_err_s = 1'b0;
                    end
                end
                default: proto_err_s = 1'b0;
            endcase
        end else begin
            complete_s = 1'b0;
        end
    end

    assign lat_s = cur_cycle - cmpl_inj_s;
    assign sum_s = {1'b0, lat_sum_q} + {{(LAT_SIZE + 1 - CYCLE_SIZE){1'b0}}, lat_s};

    // Statistics, header latch and sticky flags
    always_comb begin
        credit_d     = pop_s;
        pkt_count_d  = pkt_count_q;
        lat_sum_d    = lat_sum_q;
        last_src_d   = last_src_q;
        pkt_src_d    = pkt_src_q;
        inj_cycle_d  = inj_cycle_q;
        if (complete_s) begin
            pkt_count_d = pkt_count_q + CNT_SIZE'(1);
            lat_sum_d   = sum_s[LAT_SIZE] ? {LAT_SIZE{1'b1}} : sum_s[LAT_SIZE-1:0];
            last_src_d  = cmpl_src_s;
        end else begin
            pkt_count_d = pkt_count_q;
        end
        if (restart_s) begin
            pkt_src_d   = pop_src_s;
            inj_cycle_d = pop_cycle_s;
        end else begin
            pkt_src_d   = pkt_src_q;
        end
        enter_done_s = (expected_pkts != {CNT_SIZE{1'b0}}) && (pkt_count_d == expected_pkts);
        done_d       = done_q || enter_done_s;
        error_d      = error_q || proto_err_s || overflow_s;
    end

    // Output and context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q    <= 1'b0;
            pkt_count_q <= {CNT_SIZE{1'b0}};
            lat_sum_q   <= {LAT_SIZE{1'b0}};
            last_src_q  <= {ROUTER_BIT{1'b0}};
            pkt_src_q   <= {ROUTER_BIT{1'b0}};
            inj_cycle_q <= {CYCLE_SIZE{1'b0}};
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            pkt_count_q <= pkt_count_d;
            lat_sum_q   <= lat_sum_d;
            last_src_q  <= last_src_d;
            pkt_src_q   <= pkt_src_d;
            inj_cycle_q <= inj_cycle_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign credit_out = credit_q;
    assign pkt_count  = pkt_count_q;
    assign lat_sum    = lat_sum_q;
    assign last_src   = last_src_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_flit_sink.sv
// Randomized and directed bench for flit_sink against a queue-based packet
// model that applies the flow-control and reassembly rules per clock edge.
module tb_flit_sink;

    localparam int RB    = 4;
    localparam int DS    = 32;
    localparam int CS    = 16;
    localparam int DEPTH = 4;
    localparam int CNT   = 16;
    localparam int LAT   = 32;
    localparam int FS    = 3 + RB + DS;

    logic          clk = 1'b0;
    logic          rst;
    logic [FS-1:0] in_flit;
    logic          drain_en;
    logic [CS-1:0] cur_cycle;
    logic [CNT-1:0] expected_pkts;
    logic          credit_out;
    logic [CNT-1:0] pkt_count;
    logic [LAT-1:0] lat_sum;
    logic [RB-1:0] last_src;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    flit_sink dut (
        .clk           (clk),
        .rst           (rst),
        .in_flit       (in_flit),
        .drain_en      (drain_en),
        .cur_cycle     (cur_cycle),
        .expected_pkts (expected_pkts),
        .credit_out    (credit_out),
        .pkt_count     (pkt_count),
        .lat_sum       (lat_sum),
        .last_src      (last_src),
        .done          (done),
        .error         (error)
    );

    int n_checks    = 0;
    int n_errors    = 0;
    int credit_seen = 0;

    // reference model state
    logic [FS-1:0] mq[$];
    bit            m_in_pkt, m_done, m_err, m_credit;
    logic [15:0]   m_inj, m_cnt;
    logic [3:0]    m_src, m_last;
    longint        m_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [3:0] s, input logic [15:0] c);
        logic [15:0] hi;
        hi = 16'($urandom);
        return {1'b1, t, s, hi, c};
    endfunction

    task automatic finish_pkt(input logic [15:0] inj, input logic [3:0] s);
        logic [15:0] d;
        d = cur_cycle - inj;
        m_cnt = m_cnt + 16'd1;
        m_lat = m_lat + longint'(d);
        if (m_lat > 64'h0000_0000_FFFF_FFFF) m_lat = 64'h0000_0000_FFFF_FFFF;
        m_last = s;
    endtask

    task automatic model_edge();
        logic [FS-1:0] f;
        logic [1:0]    t;
        int            pre;
        if (rst) begin
            mq.delete();
            m_in_pkt = 0; m_done = 0; m_err = 0; m_credit = 0;
            m_inj = 16'd0; m_cnt = 16'd0; m_src = 4'd0; m_last = 4'd0; m_lat = 0;
        end else begin
            pre = mq.size();
            m_credit = drain_en && (pre > 0);
            if (m_credit) begin
                f = mq.pop_front();
                t = f[FS-2 -: 2];
                if (m_done) begin
                    if (t != 2'b00) m_err = 1;
                end else if (!m_in_pkt) begin
                    if (t == 2'b01) begin
                        m_in_pkt = 1; m_inj = f[15:0]; m_src = f[35:32];
                    end else if (t == 2'b11) begin
                        finish_pkt(f[15:0], f[35:32]);
                    end else begin
                        m_err = 1;
                    end
                end else begin
                    if (t == 2'b10) begin
                        finish_pkt(m_inj, m_src); m_in_pkt = 0;
                    end else if (t == 2'b01) begin
                        m_err = 1; m_inj = f[15:0]; m_src = f[35:32];
                    end else if (t == 2'b11) begin
                        m_err = 1; finish_pkt(f[15:0], f[35:32]); m_in_pkt = 0;
                    end
                end
            end
            if (in_flit[FS-1]) begin
                if (pre == DEPTH && !m_credit) m_err = 1;
                else mq.push_back(in_flit);
            end
            if (!m_done && expected_pkts != 16'd0 && m_cnt == expected_pkts) m_done = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("credit_out", 64'(credit_out), 64'(m_credit));
        check("pkt_count", 64'(pkt_count), 64'(m_cnt));
        check("lat_sum", 64'(lat_sum), 64'(m_lat[31:0]));
        check("last_src", 64'(last_src), 64'(m_last));
        check("done", 64'(done), 64'(m_done));
        check("error", 64'(error), 64'(m_err));
        if (credit_out) credit_seen++;
        cur_cycle = cur_cycle + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_flit = '0;
        step();
        rst = 1'b0;
    endtask

    bit gen_in_pkt;

    initial begin
        rst = 1'b1; in_flit = '0; drain_en = 1'b0; cur_cycle = 16'd0; expected_pkts = 16'd0;
        step();
        check("reset_count", 64'(pkt_count), 64'd0);
        rst = 1'b0;

        // single packet: inj 10, popped at cycle 17
        do_reset();
        expected_pkts = 16'd0; drain_en = 1'b1; cur_cycle = 16'd16; credit_seen = 0;
        in_flit = mk(2'b11, 4'd3, 16'd10); step();
        in_flit = '0; step();
        check("t1_count", 64'(pkt_count), 64'd1);
        check("t1_lat", 64'(lat_sum), 64'd7);
        check("t1_src", 64'(last_src), 64'd3);
        step();
        check("t1_credits", 64'(credit_seen), 64'd1);

        // multi-flit packet, tail popped at cycle 108
        do_reset();
        expected_pkts = 16'd1; drain_en = 1'b1; cur_cycle = 16'd104; credit_seen = 0;
        in_flit = mk(2'b01, 4'd9, 16'd100); step();
        in_flit = mk(2'b00, 4'd9, 16'd0);   step();
        in_flit = mk(2'b00, 4'd9, 16'd0);   step();
        check("t2_done_early", 64'(done), 64'd0);
        in_flit = mk(2'b10, 4'd9, 16'd0);   step();
        in_flit = '0; step();
        check("t2_done", 64'(done), 64'd1);
        check("t2_lat", 64'(lat_sum), 64'd8);
        check("t2_credits", 64'(credit_seen), 64'd4);

        // backpressure: fifth flit into a full buffer is dropped
        do_reset();
        expected_pkts = 16'd0; drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_flit = mk(2'b11, 4'(i), 16'(cur_cycle)); step();
        end
        check("t3_no_err", 64'(error), 64'd0);
        in_flit = mk(2'b11, 4'd7, 16'(cur_cycle)); step();
        check("t3_overflow", 64'(error), 64'd1);
        in_flit = '0; drain_en = 1'b1; credit_seen = 0;
        for (int i = 0; i < 6; i++) step();
        check("t3_drained", 64'(credit_seen), 64'd4);
        check("t3_count", 64'(pkt_count), 64'd4);
        do_reset();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_flit = mk(2'b11, 4'(i), 16'(cur_cycle)); step();
        end
        drain_en = 1'b1; in_flit = mk(2'b11, 4'd12, 16'(cur_cycle)); step();
        check("t3_full_pop_ok", 64'(error), 64'd0);
        in_flit = '0;
        for (int i = 0; i < 6; i++) step();
        check("t3_all_five", 64'(pkt_count), 64'd5);
        check("t3_last", 64'(last_src), 64'd12);

        // protocol errors: tail in idle, then head restart inside a packet
        do_reset();
        drain_en = 1'b1; cur_cycle = 16'd50;
        in_flit = mk(2'b10, 4'd1, 16'd0); step();
        in_flit = '0; step();
        check("t4_tail_err", 64'(error), 64'd1);
        check("t4_tail_cnt", 64'(pkt_count), 64'd0);
        in_flit = mk(2'b01, 4'd2, 16'd5);  step();
        in_flit = mk(2'b01, 4'd6, 16'd48); step();
        in_flit = mk(2'b10, 4'd0, 16'd0);  step();
        in_flit = '0; step();
        check("t4_restart_lat", 64'(lat_sum), 64'(16'(cur_cycle - 16'd1 - 16'd48)));
        check("t4_restart_src", 64'(last_src), 64'd6);

        // timestamp wrap
        do_reset();
        cur_cycle = 16'h0002;
        in_flit = mk(2'b11, 4'd5, 16'hFFFE); step();
        in_flit = '0; step();
        check("t5_wrap", 64'(lat_sum), 64'd5);

        // reset mid-packet discards buffered flits
        do_reset();
        in_flit = mk(2'b01, 4'd4, 16'(cur_cycle)); step();
        in_flit = mk(2'b00, 4'd4, 16'd0); step();
        credit_seen = 0;
        do_reset();
        step();
        check("t6_no_credit", 64'(credit_seen), 64'd0);
        in_flit = mk(2'b11, 4'd11, 16'(cur_cycle - 16'd3)); step();
        in_flit = '0; step();
        check("t6_count", 64'(pkt_count), 64'd1);
        check("t6_lat", 64'(lat_sum), 64'd4);

        // randomized traffic with occasional malformed flits and resets
        do_reset();
        gen_in_pkt = 0;
        expected_pkts = 16'($urandom_range(0, 30));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                gen_in_pkt = 0;
                expected_pkts = 16'($urandom_range(0, 30));
            end else begin
                logic [1:0] t;
                drain_en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 29) == 0) t = 2'($urandom);
                    else if (!gen_in_pkt) t = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b01;
                    else t = ($urandom_range(0, 4) < 3) ? 2'b00 : 2'b10;
                    if (t == 2'b01) gen_in_pkt = 1;
                    else if (t != 2'b00) gen_in_pkt = 0;
                    in_flit = mk(t, 4'($urandom), 16'(cur_cycle - 16'($urandom_range(0, 300))));
                end else begin
                    in_flit = {1'b0, (FS-1)'({$urandom, $urandom})};
                end
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
